// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sum/BCD stage: widths, FSM states,
// display limit and the per-digit double-dabble correction.
package calc_pkg;

  localparam int DEF_OP_W   = 8;
  localparam int DEF_SUM_W  = DEF_OP_W + 1;
  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 3;
  localparam int DISP_LIMIT = 99;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Double-dabble correction: a digit of 5 or more would exceed 9 after the
  // next shift, so pre-add 3 to make it carry into the next digit instead.
  function automatic logic [DIGIT_W-1:0] add3_if_ge5(input logic [DIGIT_W-1:0] d);
    return (d >= DIGIT_W'(5)) ? d + DIGIT_W'(3) : d;
  endfunction

endpackage

// File: rtl/sum_bcd_converter_if.sv
// Handshake and data bundle between the operand converters, this stage and
// the seven-segment display path.
interface sum_bcd_converter_if #(
  parameter int OP_W  = 8,
  parameter int SUM_W = 9
) ();

  logic              i_Start;
  logic              i_Abort;
  logic [OP_W-1:0]   i_Op_A;
  logic [OP_W-1:0]   i_Op_B;
  logic              o_Busy;
  logic              o_Done;
  logic [SUM_W-1:0]  o_Sum;
  logic [3:0]        o_Hundreds;
  logic [3:0]        o_Tens;
  logic [3:0]        o_Ones;
  logic              o_Overflow;

  // Converter side
  modport slave (
    input  i_Start, i_Abort, i_Op_A, i_Op_B,
    output o_Busy, o_Done, o_Sum, o_Hundreds, o_Tens, o_Ones, o_Overflow
  );

  // Requester side
  modport master (
    output i_Start, i_Abort, i_Op_A, i_Op_B,
    input  o_Busy, o_Done, o_Sum, o_Hundreds, o_Tens, o_Ones, o_Overflow
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// Combinational add-3-if->=5 correction for one BCD digit.
module bcd_digit_adjust
  import calc_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_Digit,
  output logic [DIGIT_W-1:0] o_Digit
);

  assign o_Digit = add3_if_ge5(i_Digit);

endmodule

// File: rtl/sum_bcd_converter.sv
// Adds two binary operands and converts the sum to three BCD digits with a
// serial double-dabble (one bit per clock). Results are held until the next
// completed conversion; an abort or reset leaves no partial result visible.
module sum_bcd_converter
  import calc_pkg::*;
#(
  parameter int OP_W  = DEF_OP_W,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  sum_bcd_converter_if.slave  bus
);

  localparam int BCD_W = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(SUM_W + 1);

  state_t                   r_state;
  state_t                   w_state_next;

  logic [SUM_W-1:0]         r_sum_sh;
  logic [SUM_W-1:0]         r_sum_ld;
  logic [BCD_W-1:0]         r_bcd;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_ovf_nxt;

  logic [SUM_W-1:0]         r_sum_out;
  logic [DIGIT_W-1:0]       r_hundreds;
  logic [DIGIT_W-1:0]       r_tens;
  logic [DIGIT_W-1:0]       r_ones;
  logic                     r_ovf_out;
  logic                     r_busy;
  logic                     r_done;

  logic [OP_W-1:0]          w_op_a;
  logic [OP_W-1:0]          w_op_b;
  logic [SUM_W-1:0]         w_sum;
  logic                     w_accept;
  logic [BCD_W-1:0]         w_bcd_adj;
  logic [BCD_W+SUM_W-1:0]   w_shift;
  logic                     w_done_next;
  logic                     w_busy_next;

  assign w_op_a = bus.i_Op_A;
  assign w_op_b = bus.i_Op_B;

  // Full-width add: the carry is kept so 255+255 yields 510.
  assign w_sum = SUM_W'(w_op_a) + SUM_W'(w_op_b);

  // Abort outranks start, so a simultaneous request never loads.
  assign w_accept = (r_state == IDLE) && bus.i_Start && !bus.i_Abort;

  // Correct every digit, then shift the whole {bcd, sum} pair left by one.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      bcd_digit_adjust u_adj (
        .i_Digit (r_bcd[gi*DIGIT_W +: DIGIT_W]),
        .o_Digit (w_bcd_adj[gi*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  assign w_shift = {w_bcd_adj, r_sum_sh} << 1;

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic: abort returns to IDLE from anywhere.
  always_comb begin
    w_state_next = r_state;
    if (bus.i_Abort) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.i_Start) w_state_next = SHIFT;
        SHIFT:   if (r_cnt == CNT_W'(1)) w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Output decode: busy covers SHIFT plus the DONE cycle, done only on an
  // un-aborted DONE.
  always_comb begin
    w_done_next = (r_state == DONE) && !bus.i_Abort;
    w_busy_next = (w_state_next != IDLE) || w_done_next;
  end

  // Shift datapath: load on accepted start, adjust+shift while in SHIFT.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sum_sh  <= '0;
      r_sum_ld  <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf_nxt <= 1'b0;
    end else if (w_accept) begin
      r_sum_sh  <= w_sum;
      r_sum_ld  <= w_sum;
      r_bcd     <= '0;
      r_cnt     <= CNT_W'(SUM_W);
      r_ovf_nxt <= (w_sum > SUM_W'(DISP_LIMIT));
    end else if ((r_state == SHIFT) && !bus.i_Abort) begin
      r_bcd     <= w_shift[BCD_W+SUM_W-1:SUM_W];
      r_sum_sh  <= w_shift[SUM_W-1:0];
      r_cnt     <= r_cnt - CNT_W'(1);
    end
  end

  // Result registers: updated only on a completed conversion.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sum_out  <= '0;
      r_hundreds <= '0;
      r_tens     <= '0;
      r_ones     <= '0;
      r_ovf_out  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      r_done <= w_done_next;
      if (w_done_next) begin
        r_sum_out  <= r_sum_ld;
        r_hundreds <= r_bcd[2*DIGIT_W +: DIGIT_W];
        r_tens     <= r_bcd[1*DIGIT_W +: DIGIT_W];
        r_ones     <= r_bcd[0*DIGIT_W +: DIGIT_W];
        r_ovf_out  <= r_ovf_nxt;
      end
    end
  end

  assign bus.o_Busy     = r_busy;
  assign bus.o_Done     = r_done;
  assign bus.o_Sum      = r_sum_out;
  assign bus.o_Hundreds = r_hundreds;
  assign bus.o_Tens     = r_tens;
  assign bus.o_Ones     = r_ones;
  assign bus.o_Overflow = r_ovf_out;

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Directed bench for sum_bcd_converter: latency, busy window, digit results,
// overflow boundary, ignored restart, abort and asynchronous reset.
module tb_sum_bcd_converter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sum_bcd_converter_if bus ();

  sum_bcd_converter dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int h, input int t,
                               input int o, input int sum, input int ovf);
    check({tag, ".hundreds"}, bus.o_Hundreds, h);
    check({tag, ".tens"},     bus.o_Tens,     t);
    check({tag, ".ones"},     bus.o_Ones,     o);
    check({tag, ".sum"},      bus.o_Sum,      sum);
    check({tag, ".ovf"},      bus.o_Overflow, ovf);
  endtask

  // Called 1 time unit after a rising edge. Edge 0 is the start edge.
  // restart_edge / abort_edge: edge at which an extra start / an abort is
  // sampled (-1 for none).
  task automatic run_conv(input string tag, input int a, input int b,
                          input int restart_edge, input int abort_edge,
                          input int exp_done_at, input int exp_done_cnt,
                          input int exp_busy,
                          input int h, input int t, input int o,
                          input int sum, input int ovf);
    int done_at;
    int done_cnt;
    int busy_cnt;
    done_at  = -1;
    done_cnt = 0;
    busy_cnt = 0;
    bus.i_Op_A  = a[7:0];
    bus.i_Op_B  = b[7:0];
    bus.i_Start = 1'b1;
    bus.i_Abort = (abort_edge == 0);
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    bus.i_Op_A  = ~a[7:0];
    bus.i_Op_B  = ~b[7:0];
    for (int k = 0; k < 20; k++) begin
      if (bus.o_Busy === 1'b1) busy_cnt++;
      if (bus.o_Done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == restart_edge - 1) begin
        bus.i_Op_A  = 8'd1;
        bus.i_Op_B  = 8'd1;
        bus.i_Start = 1'b1;
      end
      if (k == restart_edge) bus.i_Start = 1'b0;
      if (k == abort_edge - 1) bus.i_Abort = 1'b1;
      if (k == abort_edge)     bus.i_Abort = 1'b0;
      @(posedge clk); #1;
    end
    check({tag, ".done_at"},   done_at,  exp_done_at);
    check({tag, ".done_cnt"},  done_cnt, exp_done_cnt);
    check({tag, ".busy_cyc"},  busy_cnt, exp_busy);
    check_outputs(tag, h, t, o, sum, ovf);
    $display("conv %s: A=%0d B=%0d -> %0d/%0d/%0d sum=%0d ovf=%0d done_at=%0d busy=%0d",
             tag, a, b, bus.o_Hundreds, bus.o_Tens, bus.o_Ones, bus.o_Sum,
             bus.o_Overflow, done_at, busy_cnt);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.i_Start = 1'b0;
    bus.i_Abort = 1'b0;
    bus.i_Op_A  = '0;
    bus.i_Op_B  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", bus.o_Busy, 0);
    check("reset.done", bus.o_Done, 0);
    check_outputs("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_conv("add_12_34",     12,  34, -1, -1, 10, 1, 11, 0, 4, 6,  46, 0);
    run_conv("abort_20_30",   20,  30, -1,  4, -1, 0,  4, 0, 4, 6,  46, 0);
    run_conv("abort_start",   40,  40, -1,  0, -1, 0,  0, 0, 4, 6,  46, 0);
    run_conv("add_99_99",     99,  99, -1, -1, 10, 1, 11, 1, 9, 8, 198, 1);
    run_conv("add_50_49",     50,  49, -1, -1, 10, 1, 11, 0, 9, 9,  99, 0);
    run_conv("add_255_255",  255, 255, -1, -1, 10, 1, 11, 5, 1, 0, 510, 1);
    run_conv("add_0_0",        0,   0, -1, -1, 10, 1, 11, 0, 0, 0,   0, 0);
    run_conv("restart_7_8",    7,   8,  3, -1, 10, 1, 11, 0, 1, 5,  15, 0);

    // Asynchronous reset just after edge 5 of a conversion.
    bus.i_Op_A  = 8'd12;
    bus.i_Op_B  = 8'd34;
    bus.i_Start = 1'b1;
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.busy", bus.o_Busy, 0);
    check("async_rst.done", bus.o_Done, 0);
    check_outputs("async_rst", 0, 0, 0, 0, 0);
    $display("conv async_rst: outputs %0d/%0d/%0d sum=%0d busy=%0d",
             bus.o_Hundreds, bus.o_Tens, bus.o_Ones, bus.o_Sum, bus.o_Busy);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_conv("after_rst_60_45", 60, 45, -1, -1, 10, 1, 11, 1, 0, 5, 105, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sum_bcd_converter.md
# sum_bcd_converter

Sequential stage directly downstream of the two BCD-to-binary operand converters in the calculator datapath. Adds the two binary operands, converts the sum to three BCD digits by serial double-dabble (one bit per clock), and presents the digits plus an overflow flag to the seven-segment display path. Single start/done handshake; the result is held until the next completed conversion.

## Interface
- OP_W, 8: width of each binary operand.
- SUM_W, 9: width of sum (OP_W+1); also the number of shift iterations.
- i_Clk  in  1  system clock; all state changes on rising edge.
- i_Rst_L  in  1  reset; one clock; reset is asynchronous and active-low.
- i_Start  in  1  request conversion; sampled only in IDLE.
- i_Abort  in  1  synchronous cancel (driven from the reset button flag).
- i_Op_A  in  OP_W  first operand, binary, unsigned.
- i_Op_B  in  OP_W  second operand, binary, unsigned.
- o_Busy  out  1  high while a conversion is in progress.
- o_Done  out  1  one-cycle pulse when new digits are valid.
- o_Sum  out  SUM_W  registered binary sum.
- o_Hundreds / o_Tens / o_Ones  out  4 each  BCD result digits.
- o_Overflow  out  1  sum > 99 (does not fit the two-digit display).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: on i_Start=1, load sum_sh <= i_Op_A + i_Op_B (full SUM_W, no truncation), bcd <= 0, cnt <= SUM_W, ovf_nxt <= (sum > 99); go to SHIFT.
- SHIFT: each cycle, per 4-bit digit of bcd, add 3 if digit >= 5; then shift {bcd, sum_sh} left by 1; cnt decrements. When cnt reaches 0 after the shift (the SUM_W-th shift), go to DONE.
- DONE: latch bcd into o_Hundreds/o_Tens/o_Ones, ovf_nxt into o_Overflow, the loaded sum into o_Sum; o_Done=1 for this cycle only; return to IDLE.
- o_Busy = 1 in SHIFT and DONE, 0 in IDLE.
- i_Start in SHIFT or DONE: ignored, not queued.
- i_Abort in any state: next state IDLE, no o_Done, result outputs keep previous values. i_Abort and i_Start together in IDLE: abort wins, no conversion.
- Operands are sampled only on the start edge; later changes have no effect.
- Max sum 510 -> hundreds digit 0..5; digit values never exceed 9.
- Asynchronous reset (any state, including mid-conversion): state IDLE; o_Busy, o_Done, o_Overflow, o_Sum, all digits = 0; internal shift registers and counter cleared.

## Timing
- Edge 0: i_Start sampled in IDLE; o_Busy high after edge 0.
- Edges 1..9: nine adjust+shift iterations (SUM_W=9).
- Edge 10: DONE registers outputs; o_Done high for exactly the cycle after edge 10; o_Busy low after edge 11.
- Start-to-done latency: 10 clocks; back-to-back throughput one result per 11 clocks (start accepted the cycle after o_Done).
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package calc_pkg: state enum (IDLE, SHIFT, DONE), OP_W/SUM_W defaults, BCD digit width (4), display limit constant 99.
- Sub-module bcd_digit_adjust: combinational 4-bit add-3-if->=5, instantiated three times inside the shift datapath.

## Test plan
- A=12, B=34, start -> o_Done pulse 10 clocks later; digits 0/4/6, o_Sum=46, o_Overflow=0, o_Busy high for 11 cycles.
- A=99, B=99 -> digits 1/9/8, o_Sum=198, o_Overflow=1; A=50, B=49 -> 0/9/9, o_Overflow=0 (boundary).
- A=255, B=255 -> 5/1/0, o_Sum=510; A=0, B=0 -> 0/0/0, o_Overflow=0.
- Start with A=7,B=8, pulse i_Start again at edge 3 with A=1,B=1 -> single o_Done, result 0/1/5, second start ignored.
- After a 0/4/6 result, start A=20,B=30, assert i_Abort at edge 4 -> no o_Done, outputs stay 0/4/6, o_Busy low next cycle.
- Drop i_Rst_L asynchronously at edge 5 of a conversion -> all outputs 0 immediately, IDLE; new start after release completes normally.
